// File: rtl/a_74hc283.sv
// ---------------------------------------------------------------------------
// a_74hc283 -- cascadable 4-bit-slice carry-lookahead binary adder
//
// Behaves like a 74HC283 chained to WIDTH bits. {Cout,Sum} = A + B + Cin is
// produced purely combinationally, so the adder works with the clock idle.
// A registered copy of the result, with a one-cycle valid strobe, is also
// provided for synchronous datapaths.
//
// Parameters:
//   WIDTH   operand width, a positive multiple of 4 (one lookahead slice
//           per 4 bits, slices rippled together)
//
// Ports:
//   clk      in   rising-edge clock, registered path only
//   rst_n    in   asynchronous active-low reset, clears registered outputs
//   A, B     in   WIDTH-bit unsigned operands
//   Cin      in   carry in (weight 1)
//   en       in   capture strobe for the registered path
//   Sum      out  combinational (A+B+Cin) mod 2^WIDTH
//   Cout     out  combinational carry out (bit WIDTH of A+B+Cin)
//   sum_q    out  registered Sum
//   cout_q   out  registered Cout
//   valid_q  out  high the cycle after an en capture
//
// Optional status flags (macro A283_STATUS_EN):
//   zero/ovf/neg      combinational: Sum==0, signed overflow, Sum MSB
//   zero_q/ovf_q/neg_q registered copies, captured/reset like sum_q
// ---------------------------------------------------------------------------
module a_74hc283 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             en,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             valid_q
`ifdef A283_STATUS_EN
    ,
    output logic             zero,
    output logic             ovf,
    output logic             neg,
    output logic             zero_q,
    output logic             ovf_q,
    output logic             neg_q
`endif
);

    localparam int NSLICE = WIDTH / 4;

    generate
        if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
            $error("a_74hc283: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    logic [WIDTH-1:0]  g;        // per-bit generate
    logic [WIDTH-1:0]  p;        // per-bit propagate
    logic [WIDTH-1:0]  c;        // carry into each bit
    logic [NSLICE:0]   slice_c;  // carry between slices

    assign g       = A & B;
    assign p       = A ^ B;
    assign slice_c[0] = Cin;

    // Each slice computes its internal carries and carry-out directly from
    // its own g/p and the slice carry-in; slices ripple into one another.
    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice
            logic [3:0] sg;
            logic [3:0] sp;
            logic       c0;

            assign sg = g[4*gi +: 4];
            assign sp = p[4*gi +: 4];
            assign c0 = slice_c[gi];

            assign c[4*gi]     = c0;
            assign c[4*gi + 1] = sg[0] | (sp[0] & c0);
            assign c[4*gi + 2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & c0);
            assign c[4*gi + 3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0])
                               | (sp[2] & sp[1] & sp[0] & c0);
            assign slice_c[gi + 1] = sg[3]
                               | (sp[3] & sg[2])
                               | (sp[3] & sp[2] & sg[1])
                               | (sp[3] & sp[2] & sp[1] & sg[0])
                               | (sp[3] & sp[2] & sp[1] & sp[0] & c0);

            assign Sum[4*gi +: 4] = sp ^ c[4*gi +: 4];
        end
    endgenerate

    assign Cout = slice_c[NSLICE];

`ifdef A283_STATUS_EN
    assign zero = (Sum == '0);
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf  = c[WIDTH-1] ^ Cout;
    assign neg  = Sum[WIDTH-1];
`endif

    // Registered result path; reset acts immediately, without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef A283_STATUS_EN
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            valid_q <= en;
            if (en) begin
                sum_q  <= Sum;
                cout_q <= Cout;
`ifdef A283_STATUS_EN
                zero_q <= zero;
                ovf_q  <= ovf;
                neg_q  <= neg;
`endif
            end
        end
    end

endmodule

// File: tb/tb_a_74hc283.sv
module tb_a_74hc283;

    logic       clk;
    logic       clk_on;
    logic       rst_n;
    logic       en;

    // 4-bit instance
    logic [3:0] a4, b4, sum4, sum4_q;
    logic       cin4, cout4, cout4_q, valid4_q;

    // 8-bit instance (two cascaded slices)
    logic [7:0] a8, b8, sum8, sum8_q;
    logic       cin8, cout8, cout8_q, valid8_q;

`ifdef A283_STATUS_EN
    logic zero4, ovf4, neg4, zero4_q, ovf4_q, neg4_q;
    logic zero8, ovf8, neg8, zero8_q, ovf8_q, neg8_q;
`endif

    int n_cmp;
    int n_err;

    a_74hc283 #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4), .en(en),
        .Sum(sum4), .Cout(cout4), .sum_q(sum4_q), .cout_q(cout4_q),
        .valid_q(valid4_q)
`ifdef A283_STATUS_EN
        , .zero(zero4), .ovf(ovf4), .neg(neg4),
        .zero_q(zero4_q), .ovf_q(ovf4_q), .neg_q(neg4_q)
`endif
    );

    a_74hc283 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8), .en(en),
        .Sum(sum8), .Cout(cout8), .sum_q(sum8_q), .cout_q(cout8_q),
        .valid_q(valid8_q)
`ifdef A283_STATUS_EN
        , .zero(zero8), .ovf(ovf8), .neg(neg8),
        .zero_q(zero8_q), .ovf_q(ovf8_q), .neg_q(neg8_q)
`endif
    );

    // Clock stays low until the combinational checks are done.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_on) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        clk_on = 1'b0;
        // rst_n and en left undriven on purpose
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;

        // Combinational path, no clock
        a4 = 4'd4; b4 = 4'd5; cin4 = 1'b0; #1;
        check("sum 4+5+0", {27'd0, cout4, sum4}, 32'd9);
        cin4 = 1'b1; #1;
        check("sum 4+5+1", {27'd0, cout4, sum4}, 32'd10);

        a4 = 4'd12; b4 = 4'd5; cin4 = 1'b1; #23;
        check("sum 12+5+1", {27'd0, cout4, sum4}, {27'd0, 1'b1, 4'd2});
        cin4 = 1'b0; #23;
        check("sum 12+5+0", {27'd0, cout4, sum4}, {27'd0, 1'b1, 4'd1});

        a4 = 4'd15; b4 = 4'd15; cin4 = 1'b1; #1;
        check("sum 15+15+1", {27'd0, cout4, sum4}, {27'd0, 1'b1, 4'd15});
        a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0; #1;
        check("sum 0+0+0", {27'd0, cout4, sum4}, 32'd0);

        // Exhaustive 4-bit sweep; only mismatches print a FAIL line
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; #1;
            n_cmp++;
            if ({cout4, sum4} !== (5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]))) begin
                n_err++;
                $display("FAIL sweep %0d+%0d+%0d: got 0x%0h", v[3:0], v[7:4], v[8], {cout4, sum4});
            end
        end
        $display("ok   sweep: 512 vectors done");

        // 8-bit cascade
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; #1;
        check("w8 7F+01", {23'd0, cout8, sum8}, {23'd0, 1'b0, 8'h80});
`ifdef A283_STATUS_EN
        check("w8 7F+01 flags zon", {29'd0, zero8, ovf8, neg8}, {29'd0, 3'b011});
`endif
        a8 = 8'hFF; b8 = 8'h01; #1;
        check("w8 FF+01", {23'd0, cout8, sum8}, {23'd0, 1'b1, 8'h00});
`ifdef A283_STATUS_EN
        check("w8 FF+01 flags zon", {29'd0, zero8, ovf8, neg8}, {29'd0, 3'b100});
`endif
        a8 = 8'h0F; b8 = 8'h01; #1;
        check("w8 0F+01", {23'd0, cout8, sum8}, {23'd0, 1'b0, 8'h10});
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; #1;
        check("w8 FF+FF+1", {23'd0, cout8, sum8}, {23'd0, 1'b1, 8'hFF});

        // Asynchronous reset with no clock running
        rst_n = 1'b0; #1;
        check("rst async q4", {26'd0, valid4_q, cout4_q, sum4_q}, 32'd0);
        check("rst async q8", {22'd0, valid8_q, cout8_q, sum8_q}, 32'd0);

        // Start clock; drive on negedge, sample 1 ns after posedge
        clk_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;
        a4 = 4'd9; b4 = 4'd8; cin4 = 1'b0;
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        @(posedge clk); #1;
        check("cap 9+8 q4", {26'd0, valid4_q, cout4_q, sum4_q}, {26'd0, 1'b1, 1'b1, 4'd1});
        check("cap q8", {22'd0, valid8_q, cout8_q, sum8_q}, {22'd0, 1'b1, 1'b0, 8'h80});
`ifdef A283_STATUS_EN
        check("cap q8 flags", {29'd0, zero8_q, ovf8_q, neg8_q}, {29'd0, 3'b011});
`endif

        @(negedge clk);
        en = 1'b0; a4 = 4'd3; b4 = 4'd3;
        @(posedge clk); #1;
        check("hold q4", {26'd0, valid4_q, cout4_q, sum4_q}, {26'd0, 1'b0, 1'b1, 4'd1});

        // Capture, then reset mid-cycle while valid_q is high
        @(negedge clk);
        en = 1'b1; a4 = 4'd2; b4 = 4'd3; cin4 = 1'b0;
        @(posedge clk); #1;
        check("cap 2+3 q4", {26'd0, valid4_q, cout4_q, sum4_q}, {26'd0, 1'b1, 1'b0, 4'd5});
        #2;
        rst_n = 1'b0; #1;
        check("rst mid q4", {26'd0, valid4_q, cout4_q, sum4_q}, 32'd0);
        @(posedge clk); #1;
        check("rst held q4", {26'd0, valid4_q, cout4_q, sum4_q}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        check("post rst en0 q4", {26'd0, valid4_q, cout4_q, sum4_q}, 32'd0);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        check("first cap q4", {26'd0, valid4_q, cout4_q, sum4_q}, {26'd0, 1'b1, 1'b0, 4'd5});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/a_74hc283.md
Name: a_74hc283

Overview:
- 4-bit-slice binary full adder with fast carry-lookahead, functionally equivalent to a 74HC283 and cascadable to WIDTH bits.
- Primary outputs Sum/Cout are purely combinational, so the block also works standalone with the clock idle.
- A registered copy of the result, with a valid strobe, feeds synchronous datapaths (ALU/accumulator stages).

Parameters:
- WIDTH, 4, operand width in bits; must be a positive multiple of 4; one lookahead slice per 4 bits.

Ports:
- clk  input  1  rising-edge clock for the registered result path only
- rst_n  input  1  asynchronous active-low reset; clears registered outputs only
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- Cin  input  1  carry in, weight 1
- en  input  1  capture strobe for the registered path
- Sum  output  WIDTH  combinational (A+B+Cin) mod 2^WIDTH
- Cout  output  1  combinational carry out, bit WIDTH of A+B+Cin
- sum_q  output  WIDTH  registered Sum
- cout_q  output  1  registered Cout
- valid_q  output  1  high the cycle after an en capture

Behaviour:
- {Cout,Sum} = A + B + Cin, exact (WIDTH+1)-bit unsigned result; no saturation.
- Combinational path: zero cycle latency; no dependence on clk, rst_n or en. With clk/rst_n/en undriven, Sum/Cout must still be correct.
- Per 4-bit slice, bit i: generate g=A&B, propagate p=A^B. Slice carries use explicit lookahead equations:
  - c1 = g0 | p0·c0
  - through c4 = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0·c0
- Sum bit i = p_i ^ c_i.
- Slice k carry-in = slice k-1 carry-out (ripple between slices); slice 0 carry-in = Cin.
- Registered path, async reset: when rst_n=0 then sum_q=0, cout_q=0, valid_q=0 immediately, independent of clk.
- Registered path, capture: on rising clk with rst_n=1:
  - en=1 → sum_q<=Sum, cout_q<=Cout, valid_q<=1.
  - en=0 → sum_q/cout_q hold, valid_q<=0.
- Latency: 1 cycle from en sample to registered result.
- Reset asserted mid-operation clears the registered outputs at once. The first capture after deassertion is the first rising edge with rst_n=1 and en=1.
- Boundaries:
  - all-ones + all-ones + 1 → Sum all-ones, Cout=1.
  - 0+0+0 → Sum=0, Cout=0.
  - Wrap-around is modulo 2^WIDTH, with the carry on Cout.
- X/Z on en does not affect the combinational outputs.

Optional Feature:
- Macro A283_STATUS_EN.
- When defined, adds three combinational outputs:
  - zero (1 when Sum==0)
  - ovf (signed two's-complement overflow = carry into MSB ^ Cout)
  - neg (Sum[WIDTH-1])
- When defined, also adds registered copies zero_q/ovf_q/neg_q, captured and reset exactly like sum_q.
- When undefined, these ports and logic do not exist; all other behaviour is identical.

Test Plan:
- A=4, B=5, Cin=0 → Sum=9, Cout=0 immediately (no clock); then Cin=1 → Sum=10, Cout=0.
- A=12, B=5, Cin=1 → Sum=2, Cout=1; then Cin=0 → Sum=1, Cout=1; each stimulus held 23 ns, checked before the next change.
- A=15, B=15, Cin=1 → Sum=15, Cout=1; A=0, B=0, Cin=0 → Sum=0, Cout=0; exhaustive 512-vector sweep matches A+B+Cin.
- rst_n=0 → sum_q=0, cout_q=0, valid_q=0 without a clock edge. Release, en=1, A=9, B=8, Cin=0 → next edge sum_q=1, cout_q=1, valid_q=1. en=0 next cycle → sum_q holds, valid_q=0.
- Reset mid-capture: assert rst_n=0 between edges while valid_q=1 → outputs clear asynchronously and stay 0 until the first en=1 edge after release.
- WIDTH=8 with A283_STATUS_EN: A=0x7F, B=0x01, Cin=0 → Sum=0x80, Cout=0, ovf=1, neg=1, zero=0. A=0xFF, B=0x01 → Sum=0x00, Cout=1, zero=1, ovf=0.
